// File: rtl/apb_master.sv
// ============================================================================
// Module      : apb_master
// Description : APB3 requester. Runs one command at a time through SETUP and
//               ACCESS, then returns the read data and error status.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  // APB requester
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // A zero timeout still needs a legal (1-bit) counter.
  localparam int c_CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);
  localparam bit c_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state,      w_state_nxt;
  logic                  r_psel,       w_psel_nxt;
  logic                  r_penable,    w_penable_nxt;
  logic                  r_pwrite,     w_pwrite_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr,      w_paddr_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata,     w_pwdata_nxt;
  logic                  r_rsp_valid,  w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata,  w_rsp_rdata_nxt;
  logic                  r_rsp_error,  w_rsp_error_nxt;
  logic                  r_rsp_tout,   w_rsp_tout_nxt;
  logic [c_CNT_W-1:0]    r_wait_cnt,   w_wait_cnt_nxt;
  logic [c_CNT_W-1:0]    w_wait_inc;

  // Saturating increment so an unlimited wait never wraps the counter.
  assign w_wait_inc = (r_wait_cnt == c_CNT_MAX) ? r_wait_cnt : r_wait_cnt + c_CNT_W'(1);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_rsp_tout  <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_error <= w_rsp_error_nxt;
      r_rsp_tout  <= w_rsp_tout_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_error_nxt = r_rsp_error;
    w_rsp_tout_nxt  = r_rsp_tout;
    w_wait_cnt_nxt  = r_wait_cnt;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_pwrite_nxt  = cmd_write;
          w_paddr_nxt   = cmd_addr;
          w_pwdata_nxt  = cmd_wdata;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable_nxt  = 1'b1;
        w_wait_cnt_nxt = '0;
        w_state_nxt    = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          w_rsp_rdata_nxt = r_pwrite ? '0 : PRDATA;
          w_rsp_error_nxt = PSLVERR;
          w_rsp_tout_nxt  = 1'b0;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end else begin
          w_wait_cnt_nxt = w_wait_inc;
          if (c_TIMEOUT_EN && (w_wait_inc == c_TIMEOUT)) begin
            w_rsp_rdata_nxt = '0;
            w_rsp_error_nxt = 1'b1;
            w_rsp_tout_nxt  = 1'b1;
            w_psel_nxt      = 1'b0;
            w_penable_nxt   = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign PSELx       = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_error   = r_rsp_error;
  assign rsp_timeout = r_rsp_tout;

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
// Module      : tb_apb_master
// Description : Directed self-checking bench for apb_master.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;

  int n_pass  = 0;
  int n_total = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Presents a command at the current (IDLE) negedge; returns at the SETUP-cycle negedge.
  task automatic start_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge PCLK);
    n_total++; if (PSELx !== 1'b0) $display("FAIL rst_psel: got %b want 0", PSELx); else n_pass++;
    n_total++; if (PENABLE !== 1'b0) $display("FAIL rst_penable: got %b want 0", PENABLE); else n_pass++;
    n_total++; if ({PWRITE, PADDR, PWDATA} !== 65'd0) $display("FAIL rst_apb_bus: got %b/%h/%h want 0", PWRITE, PADDR, PWDATA); else n_pass++;
    n_total++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b000) $display("FAIL rst_rsp_flags: got %b want 000", {rsp_valid, rsp_error, rsp_timeout}); else n_pass++;
    n_total++; if (rsp_rdata !== 32'd0) $display("FAIL rst_rdata: got %h want 0", rsp_rdata); else n_pass++;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    PRESETn = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic test_write();
    PREADY = 1'b1; PSLVERR = 1'b0;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL wr_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    start_cmd(1'b1, 32'h0, 32'hA5);
    n_total++; if ({PSELx, PENABLE, cmd_ready} !== 3'b100) $display("FAIL wr_setup: got sel/en/rdy %b want 100", {PSELx, PENABLE, cmd_ready}); else n_pass++;
    @(negedge PCLK);
    n_total++; if ({PSELx, PENABLE, PWRITE} !== 3'b111) $display("FAIL wr_access: got sel/en/wr %b want 111", {PSELx, PENABLE, PWRITE}); else n_pass++;
    n_total++; if (PWDATA !== 32'hA5) $display("FAIL wr_pwdata: got %h want a5", PWDATA); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL wr_early_rsp: got %b want 0", rsp_valid); else n_pass++;
    @(negedge PCLK);
    n_total++; if ({rsp_valid, rsp_error, rsp_timeout, PSELx} !== 4'b1000) $display("FAIL wr_rsp: got v/e/t/sel %b want 1000", {rsp_valid, rsp_error, rsp_timeout, PSELx}); else n_pass++;
    n_total++; if (rsp_rdata !== 32'd0) $display("FAIL wr_rdata: got %h want 0", rsp_rdata); else n_pass++;
    finish_rsp();
    n_total++; if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL wr_done: got v/rdy %b want 01", {rsp_valid, cmd_ready}); else n_pass++;
  endtask

  task automatic test_read_wait();
    PREADY = 1'b0; PRDATA = 32'hFF;
    start_cmd(1'b0, 32'h40, 32'hDEAD);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      n_total++; if ({PSELx, PENABLE, rsp_valid} !== 3'b110 || PADDR !== 32'h40 || PWRITE !== 1'b0)
        $display("FAIL rd_wait%0d: got sel/en/v %b addr %h wr %b want 110 addr 40 wr 0", i, {PSELx, PENABLE, rsp_valid}, PADDR, PWRITE);
      else n_pass++;
    end
    @(negedge PCLK);
    PREADY = 1'b1; PRDATA = 32'h3C;
    n_total++; if ({PENABLE, rsp_valid} !== 2'b10 || PADDR !== 32'h40) $display("FAIL rd_last_access: got en/v %b addr %h want 10 addr 40", {PENABLE, rsp_valid}, PADDR); else n_pass++;
    @(negedge PCLK);
    PRDATA = 32'h0;
    n_total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h3C || rsp_error !== 1'b0) $display("FAIL rd_rsp: got v %b data %h err %b want 1 3c 0", rsp_valid, rsp_rdata, rsp_error); else n_pass++;
    finish_rsp();
  endtask

  task automatic test_slave_error();
    PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'h0;
    start_cmd(1'b0, 32'h80, 32'h0);
    @(negedge PCLK);
    @(negedge PCLK);
    PREADY = 1'b1;
    @(negedge PCLK);
    n_total++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b110) $display("FAIL slverr_rsp: got v/e/t %b want 110", {rsp_valid, rsp_error, rsp_timeout}); else n_pass++;
    finish_rsp();
    // PSLVERR only while PREADY is low must not count as an error
    PREADY = 1'b0; PSLVERR = 1'b1;
    start_cmd(1'b0, 32'h84, 32'h0);
    @(negedge PCLK);
    @(negedge PCLK);
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h12;
    @(negedge PCLK);
    n_total++; if ({rsp_valid, rsp_error} !== 2'b10 || rsp_rdata !== 32'h12) $display("FAIL slverr_ignored: got v/e %b data %h want 10 12", {rsp_valid, rsp_error}, rsp_rdata); else n_pass++;
    finish_rsp();
  endtask

  task automatic test_timeout();
    PREADY = 1'b0; PRDATA = 32'h55; PSLVERR = 1'b0;
    start_cmd(1'b0, 32'hC0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge PCLK);
      n_total++; if ({PSELx, PENABLE, rsp_valid} !== 3'b110) $display("FAIL tout_wait%0d: got sel/en/v %b want 110", i, {PSELx, PENABLE, rsp_valid}); else n_pass++;
    end
    @(negedge PCLK);
    n_total++; if ({PSELx, PENABLE, rsp_valid, rsp_error, rsp_timeout} !== 5'b00111) $display("FAIL tout_abort: got sel/en/v/e/t %b want 00111", {PSELx, PENABLE, rsp_valid, rsp_error, rsp_timeout}); else n_pass++;
    n_total++; if (rsp_rdata !== 32'd0) $display("FAIL tout_rdata: got %h want 0", rsp_rdata); else n_pass++;
    finish_rsp();
    PREADY = 1'b1;
  endtask

  task automatic test_backpressure();
    PREADY = 1'b1; PRDATA = 32'h77;
    start_cmd(1'b0, 32'h10, 32'h0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRDATA = 32'h99; PSLVERR = 1'b1; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h5A;
    for (int i = 0; i < 6; i++) begin
      n_total++; if ({rsp_valid, cmd_ready, PSELx, rsp_error} !== 4'b1000 || rsp_rdata !== 32'h77 || PADDR !== 32'h10)
        $display("FAIL bp_stall%0d: got v/rdy/sel/e %b data %h addr %h want 1000 77 10", i, {rsp_valid, cmd_ready, PSELx, rsp_error}, rsp_rdata, PADDR);
      else n_pass++;
      rsp_ready = (i == 5);
      @(negedge PCLK);
    end
    rsp_ready = 1'b0; PSLVERR = 1'b0;
    n_total++; if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL bp_release: got v/rdy %b want 01", {rsp_valid, cmd_ready}); else n_pass++;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    n_total++; if (PSELx !== 1'b1 || PADDR !== 32'h20 || PWRITE !== 1'b1 || PWDATA !== 32'h5A)
      $display("FAIL bp_next_cmd: got sel %b addr %h wr %b wdata %h want 1 20 1 5a", PSELx, PADDR, PWRITE, PWDATA);
    else n_pass++;
    @(negedge PCLK);
    @(negedge PCLK);
    n_total++; if ({rsp_valid, rsp_error} !== 2'b10 || rsp_rdata !== 32'd0) $display("FAIL bp_next_rsp: got v/e %b data %h want 10 0", {rsp_valid, rsp_error}, rsp_rdata); else n_pass++;
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int n_acc = 0;
    int n_rsp = 0;
    int last_acc = -1;
    PREADY = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_wdata = 32'h1;
    for (int i = 0; i < 12; i++) begin
      if (cmd_valid && cmd_ready) begin n_acc++; last_acc = i; end
      if (rsp_valid && rsp_ready) n_rsp++;
      if (i == 11) cmd_valid = 1'b0;
      @(negedge PCLK);
    end
    rsp_ready = 1'b0;
    n_total++; if (n_acc !== 3 || last_acc !== 8) $display("FAIL b2b_accepts: got %0d last at %0d want 3 last at 8", n_acc, last_acc); else n_pass++;
    n_total++; if (n_rsp !== 3) $display("FAIL b2b_responses: got %0d want 3", n_rsp); else n_pass++;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_idle: got %b want 1", cmd_ready); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    PREADY = 1'b0;
    start_cmd(1'b0, 32'h30, 32'h0);
    @(negedge PCLK);
    n_total++; if ({PSELx, PENABLE} !== 2'b11) $display("FAIL rstmid_access: got sel/en %b want 11", {PSELx, PENABLE}); else n_pass++;
    #1 PRESETn = 1'b0;
    #1;
    n_total++; if ({PSELx, PENABLE, cmd_ready} !== 3'b001) $display("FAIL rstmid_async: got sel/en/rdy %b want 001", {PSELx, PENABLE, cmd_ready}); else n_pass++;
    @(negedge PCLK);
    PRESETn = 1'b1; PREADY = 1'b1;
    repeat (3) @(negedge PCLK);
    n_total++; if ({rsp_valid, PSELx, cmd_ready} !== 3'b001 || PADDR !== 32'd0) $display("FAIL rstmid_after: got v/sel/rdy %b addr %h want 001 0", {rsp_valid, PSELx, cmd_ready}, PADDR); else n_pass++;
  endtask

  initial begin
    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_slave_error();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
